// File: rtl/cv32e40p_mult_arbiter.sv
// ---------------------------------------------------------------------------
// cv32e40p_mult_arbiter
//
// Shares one multiplier between two requesters: index 0 is the core EX stage
// and index 1 is an auxiliary port. The arbiter accepts one operation at a
// time and holds all of its fields in registers. It drives them to the
// multiplier until the multiplier reports ready. It then registers the result
// and returns it to the requester that issued the operation.
//
// Configuration:
//   CV32E40P_MULT_ARB_RR_EN  defined   -> round-robin arbitration between the
//                                         two requesters
//                            undefined -> fixed priority; requester 0 always
//                                         wins and no pointer register exists
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid_i/req_ready_o    per-requester operation handshake (2 bits)
//   req_operator_i             per-requester operator (2 x mul_opcode_e)
//   req_op_a/b/c_i             per-requester operands (2 x 32)
//   req_imm_i                  per-requester shift/round immediate (2 x 5)
//   req_short_signed_i         per-requester signedness (2 x 2)
//   req_short_subword_i        per-requester subword select (2 x 1)
//   mult_enable_o              multiplier enable, high while an op is issued
//   mult_*_o                   latched operation driven to the multiplier
//   mult_ready_i/mult_result_i multiplier result handshake
//   mult_ex_ready_o            result-consumed strobe back to the multiplier
//   rsp_valid_o/rsp_ready_i    per-requester response handshake (2 bits)
//   rsp_result_o               registered result (32)
// ---------------------------------------------------------------------------

package cv32e40p_mult_arbiter_pkg;

  typedef enum logic [2:0] {
    MUL_MAC32 = 3'b000,
    MUL_MSU32 = 3'b001,
    MUL_I     = 3'b010,
    MUL_IR    = 3'b011,
    MUL_DOT8  = 3'b100,
    MUL_DOT16 = 3'b101,
    MUL_H     = 3'b110
  } mul_opcode_e;

endpackage

module cv32e40p_mult_arbiter
  import cv32e40p_mult_arbiter_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,

  input  logic        [1:0]      req_valid_i,
  output logic        [1:0]      req_ready_o,
  input  mul_opcode_e [1:0]      req_operator_i,
  input  logic        [1:0][31:0] req_op_a_i,
  input  logic        [1:0][31:0] req_op_b_i,
  input  logic        [1:0][31:0] req_op_c_i,
  input  logic        [1:0][4:0]  req_imm_i,
  input  logic        [1:0][1:0]  req_short_signed_i,
  input  logic        [1:0]      req_short_subword_i,

  output logic                   mult_enable_o,
  output mul_opcode_e            mult_operator_o,
  output logic        [31:0]     mult_op_a_o,
  output logic        [31:0]     mult_op_b_o,
  output logic        [31:0]     mult_op_c_o,
  output logic        [4:0]      mult_imm_o,
  output logic        [1:0]      mult_short_signed_o,
  output logic                   mult_short_subword_o,
  input  logic                   mult_ready_i,
  input  logic        [31:0]     mult_result_i,
  output logic                   mult_ex_ready_o,

  output logic        [1:0]      rsp_valid_o,
  output logic        [31:0]     rsp_result_o,
  input  logic        [1:0]      rsp_ready_i
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  state_e      state_q, state_d;

  // Latched operation, owner and result
  logic        owner_q;
  mul_opcode_e op_q;
  logic [31:0] op_a_q, op_b_q, op_c_q;
  logic [4:0]  imm_q;
  logic [1:0]  short_signed_q;
  logic        short_subword_q;
  logic [31:0] result_q;

  logic        rsp_done;
  logic        can_accept;
  logic        grant;
  logic        grant_id;

`ifdef CV32E40P_MULT_ARB_RR_EN
  // Requester that wins the next contention
  logic        rr_q;
`endif

  // -------------------------------------------------------------------------
  // Arbitration
  // -------------------------------------------------------------------------
  always_comb begin : grant_logic
    // A new operation can be taken when idle, or in the same cycle the owner
    // consumes its response, so back-to-back operations lose no cycle.
    rsp_done   = (state_q == RESP) && rsp_ready_i[owner_q];
    can_accept = (state_q == IDLE) || rsp_done;
    // Gating with rst_n keeps req_ready_o low while reset is held even
    // though it is a combinational function of req_valid_i.
    grant      = rst_n && can_accept && (req_valid_i != 2'b00);
`ifdef CV32E40P_MULT_ARB_RR_EN
    grant_id   = (req_valid_i == 2'b11) ? rr_q : req_valid_i[1];
`else
    grant_id   = ~req_valid_i[0];
`endif
  end

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin : state_reg
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values, independent of process evaluation order.
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state
  // -------------------------------------------------------------------------
  always_comb begin : next_state
    // NOTE: a default before the case gives every path a value, so no latch
    // is inferred for state_d.
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant)        state_d = ISSUE;
      ISSUE:   if (mult_ready_i) state_d = RESP;
      RESP:    if (rsp_done)     state_d = grant ? ISSUE : IDLE;
      default:                   state_d = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs
  // -------------------------------------------------------------------------
  always_comb begin : fsm_outputs
    req_ready_o = 2'b00;
    if (grant) req_ready_o[grant_id] = 1'b1;

    mult_enable_o   = (state_q == ISSUE);
    mult_ex_ready_o = (state_q == ISSUE) && mult_ready_i;

    rsp_valid_o = 2'b00;
    if (state_q == RESP) rsp_valid_o[owner_q] = 1'b1;
  end

  // -------------------------------------------------------------------------
  // Operation, owner and result registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin : op_regs
    if (!rst_n) begin
      // NOTE: these are plain registers, not a memory array. They are reset
      // so that every multiplier-facing and response output reads zero
      // while reset is held, and a discarded operation leaves no trace.
      owner_q         <= 1'b0;
      op_q            <= MUL_MAC32;
      op_a_q          <= '0;
      op_b_q          <= '0;
      op_c_q          <= '0;
      imm_q           <= '0;
      short_signed_q  <= '0;
      short_subword_q <= 1'b0;
      result_q        <= '0;
    end else begin
      if (grant) begin
        owner_q         <= grant_id;
        op_q            <= req_operator_i[grant_id];
        op_a_q          <= req_op_a_i[grant_id];
        op_b_q          <= req_op_b_i[grant_id];
        op_c_q          <= req_op_c_i[grant_id];
        imm_q           <= req_imm_i[grant_id];
        short_signed_q  <= req_short_signed_i[grant_id];
        short_subword_q <= req_short_subword_i[grant_id];
      end
      if (mult_ex_ready_o) result_q <= mult_result_i;
    end
  end

`ifdef CV32E40P_MULT_ARB_RR_EN
  // The pointer moves on every grant, including uncontended ones, so the
  // requester that was just served yields the next contention.
  always_ff @(posedge clk or negedge rst_n) begin : rr_reg
    if (!rst_n) begin
      rr_q <= 1'b0;
    end else if (grant) begin
      rr_q <= ~grant_id;
    end
  end
`endif

  // The multiplier sees only the latched copy, so it stays stable for the
  // whole operation whatever the requesters do meanwhile.
  assign mult_operator_o      = op_q;
  assign mult_op_a_o          = op_a_q;
  assign mult_op_b_o          = op_b_q;
  assign mult_op_c_o          = op_c_q;
  assign mult_imm_o           = imm_q;
  assign mult_short_signed_o  = short_signed_q;
  assign mult_short_subword_o = short_subword_q;
  assign rsp_result_o         = result_q;

endmodule

// File: tb/tb_cv32e40p_mult_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cv32e40p_mult_arbiter
//
// Two requester agents issue operations from queues. A multiplier stub answers
// the arbiter: MUL_H is ready in its fifth enabled cycle, and every other
// operator is ready at once. A transaction-level model predicts grants,
// issue/response timing and results every cycle. Directed sequences pin the
// model with hand-computed values.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_cv32e40p_mult_arbiter;
  import cv32e40p_mult_arbiter_pkg::*;

  typedef struct packed {
    mul_opcode_e op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [4:0]  imm;
    logic [1:0]  ss;
    logic        sw;
  } op_t;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b1;
  logic        [1:0]       req_valid_i;
  logic        [1:0]       req_ready_o;
  mul_opcode_e [1:0]       req_operator_i;
  logic        [1:0][31:0] req_op_a_i, req_op_b_i, req_op_c_i;
  logic        [1:0][4:0]  req_imm_i;
  logic        [1:0][1:0]  req_short_signed_i;
  logic        [1:0]       req_short_subword_i;
  logic                    mult_enable_o;
  mul_opcode_e             mult_operator_o;
  logic        [31:0]      mult_op_a_o, mult_op_b_o, mult_op_c_o;
  logic        [4:0]       mult_imm_o;
  logic        [1:0]       mult_short_signed_o;
  logic                    mult_short_subword_o;
  logic                    mult_ready_i;
  logic        [31:0]      mult_result_i;
  logic                    mult_ex_ready_o;
  logic        [1:0]       rsp_valid_o;
  logic        [31:0]      rsp_result_o;
  logic        [1:0]       rsp_ready_i;

  always #5 clk = ~clk;

  cv32e40p_mult_arbiter dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .req_valid_i          (req_valid_i),
    .req_ready_o          (req_ready_o),
    .req_operator_i       (req_operator_i),
    .req_op_a_i           (req_op_a_i),
    .req_op_b_i           (req_op_b_i),
    .req_op_c_i           (req_op_c_i),
    .req_imm_i            (req_imm_i),
    .req_short_signed_i   (req_short_signed_i),
    .req_short_subword_i  (req_short_subword_i),
    .mult_enable_o        (mult_enable_o),
    .mult_operator_o      (mult_operator_o),
    .mult_op_a_o          (mult_op_a_o),
    .mult_op_b_o          (mult_op_b_o),
    .mult_op_c_o          (mult_op_c_o),
    .mult_imm_o           (mult_imm_o),
    .mult_short_signed_o  (mult_short_signed_o),
    .mult_short_subword_o (mult_short_subword_o),
    .mult_ready_i         (mult_ready_i),
    .mult_result_i        (mult_result_i),
    .mult_ex_ready_o      (mult_ex_ready_o),
    .rsp_valid_o          (rsp_valid_o),
    .rsp_result_o         (rsp_result_o),
    .rsp_ready_i          (rsp_ready_i)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Arithmetic meaning of each operator as this bench defines it
  function automatic logic [31:0] mult_fn(input op_t o);
    logic [31:0] ah, bh, prod;
    logic signed [31:0] sp;
    logic [63:0] ea, eb, p64;
    case (o.op)
      MUL_MAC32: return o.a * o.b + o.c;
      MUL_MSU32: return o.c - o.a * o.b;
      MUL_I: begin
        ah = o.sw ? {16'h0, o.a[31:16]} : {16'h0, o.a[15:0]};
        bh = o.sw ? {16'h0, o.b[31:16]} : {16'h0, o.b[15:0]};
        if (o.ss[0] && ah[15]) ah[31:16] = 16'hFFFF;
        if (o.ss[1] && bh[15]) bh[31:16] = 16'hFFFF;
        prod = ah * bh;
        sp = prod;
        return sp >>> o.imm;
      end
      MUL_H: begin
        ea = {(o.ss[0] && o.a[31]) ? 32'hFFFF_FFFF : 32'h0, o.a};
        eb = {(o.ss[1] && o.b[31]) ? 32'hFFFF_FFFF : 32'h0, o.b};
        p64 = ea * eb;
        return p64[63:32];
      end
      default: return o.a * o.b;
    endcase
  endfunction

  function automatic op_t mk(input mul_opcode_e op, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] c, input logic [4:0] imm, input logic [1:0] ss,
                             input logic sw);
    op_t o;
    o = '{op: op, a: a, b: b, c: c, imm: imm, ss: ss, sw: sw};
    return o;
  endfunction

  function automatic op_t rand_op();
    op_t o;
    case ($urandom_range(0, 3))
      0:       o.op = MUL_MAC32;
      1:       o.op = MUL_MSU32;
      2:       o.op = MUL_I;
      default: o.op = MUL_H;
    endcase
    o.a = $urandom(); o.b = $urandom(); o.c = $urandom();
    o.imm = 5'($urandom_range(0, 31));
    o.ss = 2'($urandom_range(0, 3));
    o.sw = 1'($urandom_range(0, 1));
    return o;
  endfunction

  // Requester agents
  op_t  q0[$], q1[$];
  logic [1:0] presenting;
  bit   force_valid;
  int   rsp_mode;     // 0 random, 1 always ready, 2 never ready
  int   cyc = 0;

  // Multiplier stub
  int   st_cnt;

  // Reference model: one operation in flight at most
  bit   m_busy, m_rsp, m_owner, m_pri;
  op_t  m_op;
  int   m_issue;
  logic [31:0] m_result;
  bit   saw_step2;

  // Observation logs of DUT handshakes
  int   gl_id[$], gl_cyc[$], rl_cyc[$];
  logic [1:0]  rl_vld[$];
  logic [31:0] rl_res[$];
  bit   prev_rv, prev_hs;
  int   en_cnt;

  function automatic int gid_at(input int k);  return (k < gl_id.size())  ? gl_id[k]  : -1; endfunction
  function automatic int gcyc_at(input int k); return (k < gl_cyc.size()) ? gl_cyc[k] : -1000; endfunction
  function automatic int rcyc_at(input int k); return (k < rl_cyc.size()) ? rl_cyc[k] : -1; endfunction
  function automatic logic [31:0] rres_at(input int k); return (k < rl_res.size()) ? rl_res[k] : 32'hDEAD_BEEF; endfunction
  function automatic logic [1:0]  rvld_at(input int k); return (k < rl_vld.size()) ? rl_vld[k] : 2'b11; endfunction

  task automatic clear_logs();
    gl_id.delete(); gl_cyc.delete(); rl_cyc.delete(); rl_vld.delete(); rl_res.delete();
    en_cnt = 0;
  endtask

  // One clock cycle: drive at the falling edge, compare 1 ns later, then
  // advance the model to what the next rising edge must produce.
  task automatic step();
    op_t cur [2];
    op_t dut_op;
    logic [1:0] exp_rdy;
    logic gid, can_acc, exp_exr, st_ready;
    @(negedge clk);
    cyc++;
    for (int i = 0; i < 2; i++) begin
      int qs;
      qs = (i == 0) ? q0.size() : q1.size();
      if (qs == 0)                        req_valid_i[i] = 1'b0;
      else if (presenting[i] || force_valid) req_valid_i[i] = 1'b1;
      else                                req_valid_i[i] = ($urandom_range(0, 2) != 0);
      if (req_valid_i[i]) cur[i] = (i == 0) ? q0[0] : q1[0];
      else                cur[i] = rand_op();
      req_operator_i[i]      = cur[i].op;
      req_op_a_i[i]          = cur[i].a;
      req_op_b_i[i]          = cur[i].b;
      req_op_c_i[i]          = cur[i].c;
      req_imm_i[i]           = cur[i].imm;
      req_short_signed_i[i]  = cur[i].ss;
      req_short_subword_i[i] = cur[i].sw;
    end
    dut_op = {mult_operator_o, mult_op_a_o, mult_op_b_o, mult_op_c_o,
              mult_imm_o, mult_short_signed_o, mult_short_subword_o};
    st_ready = mult_enable_o && (mult_operator_o != MUL_H || st_cnt == 4);
    mult_ready_i  = st_ready;
    mult_result_i = st_ready ? mult_fn(dut_op) : $urandom();
    case (rsp_mode)
      0:       rsp_ready_i = 2'($urandom_range(0, 3));
      1:       rsp_ready_i = 2'b11;
      default: rsp_ready_i = 2'b00;
    endcase
    #1;
    exp_exr = m_busy && (m_op.op != MUL_H || m_issue == 4);
    if (m_busy && m_issue == 2) saw_step2 = 1'b1;
    can_acc = !m_busy && (!m_rsp || rsp_ready_i[m_owner]);
`ifdef CV32E40P_MULT_ARB_RR_EN
    gid = (req_valid_i == 2'b11) ? m_pri : !req_valid_i[0];
`else
    gid = !req_valid_i[0];
`endif
    exp_rdy = (can_acc && req_valid_i != 2'b00) ? (2'b01 << gid) : 2'b00;

    check("req_ready", req_ready_o, exp_rdy);
    check("mult_enable", mult_enable_o, m_busy);
    check("mult_ex_ready", mult_ex_ready_o, exp_exr);
    check("rsp_valid", rsp_valid_o, m_rsp ? (2'b01 << m_owner) : 2'b00);
    if (m_rsp)  check("rsp_result", rsp_result_o, m_result);
    if (m_busy) check("mult_fields", dut_op, m_op);

    if (req_ready_o != 2'b00) begin gl_id.push_back(req_ready_o[1] ? 1 : 0); gl_cyc.push_back(cyc); end
    if (rsp_valid_o != 2'b00 && (!prev_rv || prev_hs)) begin
      rl_vld.push_back(rsp_valid_o); rl_res.push_back(rsp_result_o); rl_cyc.push_back(cyc);
    end
    prev_rv = (rsp_valid_o != 2'b00);
    prev_hs = ((rsp_valid_o & rsp_ready_i) != 2'b00);
    en_cnt += int'(mult_enable_o);

    if (m_rsp && rsp_ready_i[m_owner]) m_rsp = 1'b0;
    if (m_busy) begin
      if (exp_exr) begin m_busy = 1'b0; m_rsp = 1'b1; m_result = mult_fn(m_op); end
      else m_issue++;
    end
    if (exp_rdy != 2'b00) begin
      m_busy = 1'b1; m_owner = gid; m_op = cur[gid]; m_issue = 0; m_pri = !gid;
      if (gid) void'(q1.pop_front()); else void'(q0.pop_front());
      presenting[gid] = 1'b0;
    end
    for (int i = 0; i < 2; i++)
      if (req_valid_i[i] && !exp_rdy[i]) presenting[i] = 1'b1;
    st_cnt = (mult_enable_o && !st_ready) ? st_cnt + 1 : 0;
  endtask

  // Asynchronous reset, possibly in mid-cycle; outputs must clear at once.
  task automatic do_reset();
    rst_n = 1'b0;
    req_valid_i = 2'b11;
    #1;
    check("rst_req_ready", req_ready_o, 2'b00);
    check("rst_mult_enable", mult_enable_o, 1'b0);
    check("rst_mult_ex_ready", mult_ex_ready_o, 1'b0);
    check("rst_rsp_valid", rsp_valid_o, 2'b00);
    check("rst_rsp_result", rsp_result_o, 32'h0);
    check("rst_mult_fields", {mult_operator_o, mult_op_a_o, mult_op_b_o, mult_op_c_o,
                              mult_imm_o, mult_short_signed_o, mult_short_subword_o}, '0);
    m_busy = 0; m_rsp = 0; m_owner = 0; m_pri = 0; m_op = '0; m_issue = 0; m_result = '0;
    presenting = 2'b00; st_cnt = 0; prev_rv = 0; prev_hs = 0;
    q0.delete(); q1.delete();
    @(negedge clk);
    @(negedge clk);
    req_valid_i = 2'b00; mult_ready_i = 1'b0; rsp_ready_i = 2'b00;
    rst_n = 1'b1;
  endtask

  task automatic drain();
    int n = 0;
    rsp_mode = 1;
    while ((q0.size() != 0 || q1.size() != 0 || m_busy || m_rsp) && n < 300) begin
      step();
      n++;
    end
    check("drain_done", (q0.size() + q1.size() + int'(m_busy) + int'(m_rsp)) == 0, 1'b1);
  endtask

  initial begin
    int n;
    req_valid_i = '0; req_operator_i = '{MUL_MAC32, MUL_MAC32};
    req_op_a_i = '0; req_op_b_i = '0; req_op_c_i = '0; req_imm_i = '0;
    req_short_signed_i = '0; req_short_subword_i = '0;
    mult_ready_i = 1'b0; mult_result_i = '0; rsp_ready_i = '0;
    force_valid = 1'b1; rsp_mode = 1; presenting = '0;
    #2 do_reset();

    // MAC32 from requester 0: 3*5+7 two cycles after accept
    clear_logs();
    q0.push_back(mk(MUL_MAC32, 32'd3, 32'd5, 32'd7, 5'd0, 2'b00, 1'b0));
    repeat (6) step();
    check("t034_grant_id", gid_at(0), 0);
    check("t034_latency", rcyc_at(0) - gcyc_at(0), 2);
    check("t034_rsp_valid", rvld_at(0), 2'b01);
    check("t034_result", rres_at(0), 32'd22);

    // Signed MUL_H from requester 1: five enable cycles, response at T+6
    clear_logs();
    q1.push_back(mk(MUL_H, 32'h8000_0000, 32'h8000_0000, 32'h0, 5'd0, 2'b11, 1'b0));
    repeat (10) step();
    check("t035_grant_id", gid_at(0), 1);
    check("t035_latency", rcyc_at(0) - gcyc_at(0), 6);
    check("t035_rsp_valid", rvld_at(0), 2'b10);
    check("t035_result", rres_at(0), 32'h4000_0000);
    check("t035_enable_cycles", en_cnt, 5);

    // Permanent contention for four operations
    do_reset();
    clear_logs();
    for (int k = 0; k < 4; k++) begin
      q0.push_back(mk(MUL_MAC32, k, k + 1, 32'd0, 5'd0, 2'b00, 1'b0));
      q1.push_back(mk(MUL_MSU32, k, 32'd2, 32'd100, 5'd0, 2'b00, 1'b0));
    end
    n = 0;
    while (gl_id.size() < 4 && n < 60) begin step(); n++; end
    check("t036_four_grants", gl_id.size() >= 4, 1'b1);
    for (int k = 0; k < 4; k++) begin
`ifdef CV32E40P_MULT_ARB_RR_EN
      check($sformatf("t036_grant%0d", k), gid_at(k), k % 2);
`else
      check($sformatf("t036_grant%0d", k), gid_at(k), 0);
`endif
    end
`ifdef CV32E40P_MULT_ARB_RR_EN
    check("t036_q1_left", q1.size(), 2);
`else
    check("t036_q1_starved", q1.size(), 4);
`endif
    drain();

    // Response held while the owner stalls; no accept, no enable
    do_reset();
    clear_logs();
    q0.push_back(mk(MUL_MAC32, 32'd2, 32'd10, 32'd1, 5'd0, 2'b00, 1'b0));
    q1.push_back(mk(MUL_MAC32, 32'd1, 32'd1, 32'd0, 5'd0, 2'b00, 1'b0));
    rsp_mode = 2;
    n = 0;
    while (rsp_valid_o == 2'b00 && n < 20) begin step(); n++; end
    check("t037_rsp_reached", rsp_valid_o != 2'b00, 1'b1);
    repeat (3) begin
      step();
      check("t037_hold_valid", rsp_valid_o, 2'b01);
      check("t037_hold_result", rsp_result_o, 32'd21);
      check("t037_hold_req_ready", req_ready_o, 2'b00);
      check("t037_hold_enable", mult_enable_o, 1'b0);
    end
    drain();

    // Back-to-back accept in the response handshake cycle
    clear_logs();
    force_valid = 1'b1; rsp_mode = 1;
    q0.push_back(mk(MUL_MAC32, 32'd1, 32'd1, 32'd1, 5'd0, 2'b00, 1'b0));
    q0.push_back(mk(MUL_I, 32'd7, 32'd6, 32'd0, 5'd1, 2'b00, 1'b0));
    repeat (8) step();
    check("t038_accept_in_resp", gcyc_at(1), rcyc_at(0));
    check("t038_second_latency", rcyc_at(1) - gcyc_at(1), 2);
    check("t038_result0", rres_at(0), 32'd2);
    check("t038_result1", rres_at(1), 32'd21);

    // Reset during MUL_H step 2 discards the operation
    do_reset();
    clear_logs();
    saw_step2 = 1'b0;
    q1.push_back(mk(MUL_H, 32'd5, 32'd7, 32'd0, 5'd0, 2'b00, 1'b0));
    n = 0;
    while (!saw_step2 && n < 20) begin step(); n++; end
    check("t039_step2_reached", saw_step2, 1'b1);
    #2 do_reset();
    repeat (4) step();
    check("t039_no_response", rl_res.size(), 0);
    clear_logs();
    q0.push_back(mk(MUL_I, 32'h0000_FFFF, 32'd3, 32'd0, 5'd0, 2'b11, 1'b0));
    repeat (5) step();
    check("t039_latency", rcyc_at(0) - gcyc_at(0), 2);
    check("t039_rsp_valid", rvld_at(0), 2'b01);
    check("t039_result", rres_at(0), 32'hFFFF_FFFD);

    // Random traffic, random stalls, random non-owner rsp_ready
    clear_logs();
    force_valid = 1'b0; rsp_mode = 0;
    repeat (600) begin
      if ($urandom_range(0, 3) == 0 && q0.size() < 4) q0.push_back(rand_op());
      if ($urandom_range(0, 3) == 0 && q1.size() < 4) q1.push_back(rand_op());
      step();
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
